// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions: DCR address/range types and the default graphics-unit DCR windows.
package VX_gpu_pkg;

  localparam int DCR_ADDR_WIDTH = 12;

  typedef logic [DCR_ADDR_WIDTH-1:0] dcr_addr_t;

  // Half-open window: begin_addr <= addr < end_addr
  typedef struct packed {
    dcr_addr_t begin_addr;
    dcr_addr_t end_addr;
  } dcr_range_t;

  localparam dcr_addr_t DCR_RASTER_BEGIN = 12'h100;
  localparam dcr_addr_t DCR_RASTER_END   = 12'h180;
  localparam dcr_addr_t DCR_TEX_BEGIN    = 12'h180;
  localparam dcr_addr_t DCR_TEX_END      = 12'h200;
  localparam dcr_addr_t DCR_OM_BEGIN     = 12'h200;
  localparam dcr_addr_t DCR_OM_END       = 12'h280;

  localparam dcr_range_t DCR_RASTER_RANGE = '{begin_addr: DCR_RASTER_BEGIN, end_addr: DCR_RASTER_END};
  localparam dcr_range_t DCR_TEX_RANGE    = '{begin_addr: DCR_TEX_BEGIN,    end_addr: DCR_TEX_END};
  localparam dcr_range_t DCR_OM_RANGE     = '{begin_addr: DCR_OM_BEGIN,     end_addr: DCR_OM_END};

endpackage

// File: rtl/vx_gfx_dcr_fifo.sv
// Per-unit DCR write buffer, 1-cycle push-to-head latency.
// Backpressure: full stays high during a same-cycle pop; the caller must not push when full or pop when empty.
module vx_gfx_dcr_fifo
  import VX_gpu_pkg::*;
#(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  // Storage is cleared too, so head is never X after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/vx_gfx_dcr_router.sv
// Routes DCR writes by address window to per-unit FIFOs (broadcast on overlap); 1-cycle latency to dcr_out_valid.
// Backpressure: dcr_in_ready drops when any matching unit FIFO is full; outputs drain whenever the unit is unlocked.
module vx_gfx_dcr_router
  import VX_gpu_pkg::*;
#(
  parameter int NUM_UNITS  = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [NUM_UNITS*ADDR_WIDTH-1:0] RANGE_BEGIN = '0,
  parameter logic [NUM_UNITS*ADDR_WIDTH-1:0] RANGE_END   = '0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             dcr_in_valid,
  output logic                             dcr_in_ready,
  input  logic [ADDR_WIDTH-1:0]            dcr_in_addr,
  input  logic [DATA_WIDTH-1:0]            dcr_in_data,
  input  logic [NUM_UNITS-1:0]             unit_lock,
  output logic [NUM_UNITS-1:0]             dcr_out_valid,
  output logic [NUM_UNITS*ADDR_WIDTH-1:0]  dcr_out_addr,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]  dcr_out_data,
  output logic [NUM_UNITS-1:0]             pending,
  output logic [CNT_WIDTH-1:0]             unmapped_count
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("vx_gfx_dcr_router: FIFO_DEPTH must be a power of two >= 2");
  end

  // An all-zero window marks an unused unit and is exempt from the ordering check
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_range_chk
    if ((RANGE_BEGIN[u*ADDR_WIDTH +: ADDR_WIDTH] != '0 || RANGE_END[u*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
        !(RANGE_BEGIN[u*ADDR_WIDTH +: ADDR_WIDTH] < RANGE_END[u*ADDR_WIDTH +: ADDR_WIDTH])) begin : g_bad_range
      $error("vx_gfx_dcr_router: RANGE_BEGIN must be below RANGE_END for every unit");
    end
  end

  logic [NUM_UNITS-1:0] hit;
  logic [NUM_UNITS-1:0] full;
  logic [NUM_UNITS-1:0] empty;
  logic [NUM_UNITS-1:0] push;
  logic                 accept;

  always_comb begin
    hit = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      hit[u] = (dcr_in_addr >= RANGE_BEGIN[u*ADDR_WIDTH +: ADDR_WIDTH]) &&
               (dcr_in_addr <  RANGE_END[u*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // All-or-none: one full target blocks the whole broadcast; unmapped writes always sink
  assign dcr_in_ready  = ~|(hit & full);
  assign accept        = dcr_in_valid && dcr_in_ready;
  assign push          = {NUM_UNITS{accept}} & hit;
  assign dcr_out_valid = ~empty & ~unit_lock;
  assign pending       = ~empty;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    logic [EW-1:0] head;

    vx_gfx_dcr_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[u]),
      .push_data ({dcr_in_addr, dcr_in_data}),
      .pop       (dcr_out_valid[u]),
      .head      (head),
      .full      (full[u]),
      .empty     (empty[u])
    );

    assign dcr_out_addr[u*ADDR_WIDTH +: ADDR_WIDTH] = head[EW-1 -: ADDR_WIDTH];
    assign dcr_out_data[u*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unmapped_count <= '0;
    end else if (accept && (hit == '0) && (unmapped_count != '1)) begin
      unmapped_count <= unmapped_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_vx_gfx_dcr_router.sv
// Scoreboard bench for vx_gfx_dcr_router: a reference model of per-unit queues checked every cycle,
// plus directed scenarios for latency, broadcast, lock stall, full blocking, counter saturation and reset.
module tb_vx_gfx_dcr_router;

  localparam int NU    = 3;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  // unit0 [100,200) unit1 [280,300) unit2 [180,280): units 0 and 2 overlap on [180,200)
  localparam logic [NU*AW-1:0] RB = {12'h180, 12'h280, 12'h100};
  localparam logic [NU*AW-1:0] RE = {12'h280, 12'h300, 12'h200};

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              dcr_in_valid = 1'b0;
  logic [AW-1:0]     dcr_in_addr = '0;
  logic [DW-1:0]     dcr_in_data = '0;
  logic [NU-1:0]     unit_lock = '0;

  logic              dcr_in_ready;
  logic [NU-1:0]     dcr_out_valid;
  logic [NU*AW-1:0]  dcr_out_addr;
  logic [NU*DW-1:0]  dcr_out_data;
  logic [NU-1:0]     pending;
  logic [15:0]       unmapped_count;

  logic              c2_in_ready;
  logic [NU-1:0]     c2_out_valid;
  logic [NU*AW-1:0]  c2_out_addr;
  logic [NU*DW-1:0]  c2_out_data;
  logic [NU-1:0]     c2_pending;
  logic [1:0]        c2_unmapped_count;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        sb [NU][$];
  logic [15:0] exp_cnt  = '0;
  logic [1:0]  exp_cnt2 = '0;

  always #5 clk = ~clk;

  vx_gfx_dcr_router #(
    .NUM_UNITS(NU), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .RANGE_BEGIN(RB), .RANGE_END(RE), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .dcr_in_valid(dcr_in_valid), .dcr_in_ready(dcr_in_ready),
    .dcr_in_addr(dcr_in_addr), .dcr_in_data(dcr_in_data),
    .unit_lock(unit_lock),
    .dcr_out_valid(dcr_out_valid), .dcr_out_addr(dcr_out_addr), .dcr_out_data(dcr_out_data),
    .pending(pending), .unmapped_count(unmapped_count)
  );

  // Same traffic into a narrow-counter instance to observe saturation
  vx_gfx_dcr_router #(
    .NUM_UNITS(NU), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .RANGE_BEGIN(RB), .RANGE_END(RE), .CNT_WIDTH(2)
  ) dut_c2 (
    .clk(clk), .reset(reset),
    .dcr_in_valid(dcr_in_valid), .dcr_in_ready(c2_in_ready),
    .dcr_in_addr(dcr_in_addr), .dcr_in_data(dcr_in_data),
    .unit_lock(unit_lock),
    .dcr_out_valid(c2_out_valid), .dcr_out_addr(c2_out_addr), .dcr_out_data(c2_out_data),
    .pending(c2_pending), .unmapped_count(c2_unmapped_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hits(input int u, input logic [AW-1:0] a);
    return (a >= RB[u*AW +: AW]) && (a < RE[u*AW +: AW]);
  endfunction

  // Reference model, sampled on the falling edge: compare state first, then apply this cycle's pops and pushes
  always @(negedge clk) begin
    logic [NU-1:0] ev;
    logic [NU-1:0] ep;
    logic          er;
    logic          any;
    ent_t          e;
    if (reset) begin
      for (int u = 0; u < NU; u++) sb[u].delete();
      exp_cnt  = '0;
      exp_cnt2 = '0;
    end else begin
      er = 1'b1;
      ev = '0;
      ep = '0;
      for (int u = 0; u < NU; u++) begin
        if (hits(u, dcr_in_addr) && sb[u].size() == DEPTH) er = 1'b0;
        ep[u] = (sb[u].size() != 0);
        ev[u] = ep[u] && !unit_lock[u];
      end
      check("in_ready", dcr_in_ready, er);
      check("in_ready_c2", c2_in_ready, er);
      check("out_valid", dcr_out_valid, ev);
      check("out_valid_c2", c2_out_valid, ev);
      check("pending", pending, ep);
      check("pending_c2", c2_pending, ep);
      check("unmapped", unmapped_count, exp_cnt);
      check("unmapped_c2", c2_unmapped_count, exp_cnt2);
      for (int u = 0; u < NU; u++) begin
        if (ev[u]) begin
          e = sb[u].pop_front();
          check($sformatf("out_addr%0d", u), dcr_out_addr[u*AW +: AW], e.a);
          check($sformatf("out_data%0d", u), dcr_out_data[u*DW +: DW], e.d);
        end
      end
      if (dcr_in_valid && dcr_in_ready) begin
        any = 1'b0;
        for (int u = 0; u < NU; u++) begin
          if (hits(u, dcr_in_addr)) begin
            sb[u].push_back('{a: dcr_in_addr, d: dcr_in_data});
            any = 1'b1;
          end
        end
        if (!any) begin
          exp_cnt = exp_cnt + 16'd1;
          if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    dcr_in_valid = 1'b1;
    dcr_in_addr  = a;
    dcr_in_data  = d;
    @(negedge clk);
    while (!dcr_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("wr_accept", dcr_in_ready, 1'b1);
    @(posedge clk);
    #1;
    dcr_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    // Reset state
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", dcr_out_valid, 3'b000);
    check("rst_pending", pending, 3'b000);
    check("rst_count", unmapped_count, 16'd0);
    check("rst_addr", dcr_out_addr, '0);
    check("rst_data", dcr_out_data, '0);
    check("rst_addr_c2", c2_out_addr, '0);
    check("rst_data_c2", c2_out_data, '0);
    idle(1);

    // Single write to unit1: valid for exactly one cycle at T+1
    wr(12'h290, 32'h1111_2222);
    @(negedge clk);
    check("u1_valid_t1", dcr_out_valid, 3'b010);
    check("u1_addr", dcr_out_addr[1*AW +: AW], 12'h290);
    check("u1_data", dcr_out_data[1*DW +: DW], 32'h1111_2222);
    @(negedge clk);
    check("u1_valid_t2", dcr_out_valid, 3'b000);
    idle(1);

    // Broadcast to overlapping units 0 and 2
    wr(12'h1C0, 32'hABCD_1234);
    @(negedge clk);
    check("bc_valid", dcr_out_valid, 3'b101);
    check("bc_data0", dcr_out_data[0*DW +: DW], 32'hABCD_1234);
    check("bc_data2", dcr_out_data[2*DW +: DW], 32'hABCD_1234);
    idle(2);

    // Random mapped traffic under randomly toggling locks
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          case ($urandom_range(0, 3))
            0: ra = 12'h120;
            1: ra = 12'h1C0;
            2: ra = 12'h220;
            default: ra = 12'h290;
          endcase
          wr(ra, $urandom());
        end
      end
      begin
        for (int c = 0; c < 80; c++) begin
          @(posedge clk);
          #1;
          unit_lock = 3'($urandom_range(0, 7));
        end
        unit_lock = '0;
      end
    join
    unit_lock = '0;
    idle(8);

    // Locked unit0 fills at depth 4; the 5th write waits until the lock releases
    unit_lock = 3'b001;
    for (int i = 0; i < 4; i++) wr(12'h100 + AW'(i), 32'hC0DE_0000 + DW'(i));
    dcr_in_valid = 1'b1;
    dcr_in_addr  = 12'h104;
    dcr_in_data  = 32'hC0DE_0004;
    repeat (3) begin
      @(negedge clk);
      check("lock_full_rdy", dcr_in_ready, 1'b0);
      check("lock_hold", dcr_out_valid, 3'b000);
    end
    @(posedge clk);
    #1;
    unit_lock = 3'b000;
    wr(12'h104, 32'hC0DE_0004);
    idle(6);

    // Broadcast blocked by a full unit2 while unit0 is empty
    unit_lock = 3'b100;
    for (int i = 0; i < 4; i++) wr(12'h210 + AW'(i), 32'h2200_0000 + DW'(i));
    dcr_in_valid = 1'b1;
    dcr_in_addr  = 12'h1C4;
    dcr_in_data  = 32'h5A5A_0001;
    repeat (3) begin
      @(negedge clk);
      check("bc_block_rdy", dcr_in_ready, 1'b0);
      check("bc_block_u0", dcr_out_valid[0], 1'b0);
      check("bc_block_p0", pending[0], 1'b0);
    end
    @(posedge clk);
    #1;
    unit_lock = 3'b000;
    wr(12'h1C4, 32'h5A5A_0001);
    idle(8);

    // Unmapped writes: counted and dropped; 2-bit counter saturates
    wr(12'h050, 32'h1);
    wr(12'h400, 32'h2);
    wr(12'hFFF, 32'h3);
    @(negedge clk);
    check("unmap3", unmapped_count, 16'd3);
    check("unmap3_c2", c2_unmapped_count, 2'd3);
    check("unmap_noout", dcr_out_valid, 3'b000);
    idle(1);
    wr(12'h000, 32'h4);
    wr(12'h300, 32'h5);
    @(negedge clk);
    check("unmap5", unmapped_count, 16'd5);
    check("unmap5_c2", c2_unmapped_count, 2'd3);
    idle(1);

    // Reset with 3 buffered writes and an in-flight handshake
    unit_lock = 3'b111;
    for (int i = 0; i < 3; i++) wr(12'h120 + AW'(i), 32'h7700_0000 + DW'(i));
    dcr_in_valid = 1'b1;
    dcr_in_addr  = 12'h130;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    dcr_in_valid = 1'b0;
    unit_lock    = 3'b000;
    @(negedge clk);
    check("mrst_pending", pending, 3'b000);
    check("mrst_valid", dcr_out_valid, 3'b000);
    check("mrst_count", unmapped_count, 16'd0);
    check("mrst_addr", dcr_out_addr, '0);
    check("mrst_data", dcr_out_data, '0);
    repeat (4) begin
      @(negedge clk);
      check("mrst_no_out", dcr_out_valid, 3'b000);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
